// File: rtl/a2bus_drv_pkg.sv
// Shared types and address constants for the Apple II slot-card read responder.
package a2bus_drv_pkg;

  localparam int unsigned CNT_W    = 6;
  localparam int unsigned OFFSET_W = 11;

  localparam logic [CNT_W-1:0] CNT_MAX = 6'd63;

  localparam logic [15:0] DEVSEL_BASE   = 16'hC080;
  localparam logic [15:0] IOSEL_BASE    = 16'hC000;
  localparam logic [15:0] IOSTROBE_BASE = 16'hC800;
  localparam logic [15:0] C8_CLEAR_ADDR = 16'hCFFF;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DRIVE,
    HOLD
  } state_t;

  typedef enum logic [1:0] {
    SPACE_DEVSEL   = 2'd0,
    SPACE_IOSEL    = 2'd1,
    SPACE_IOSTROBE = 2'd2
  } space_t;

  // Decoded target of a read: which slot space and the offset inside it.
  typedef struct packed {
    space_t                space;
    logic [OFFSET_W-1:0]   offset;
  } rd_sel_t;

  function automatic logic [15:0] devsel_addr(input int unsigned slot);
    return DEVSEL_BASE + 16'(slot * 16);
  endfunction

  function automatic logic [15:0] iosel_addr(input int unsigned slot);
    return IOSEL_BASE + 16'(slot * 256);
  endfunction

endpackage

// File: rtl/apple_bus_data_driver_if.sv
// Bus-side and data-source signals of the slot-card read responder.
interface apple_bus_data_driver_if;
  import a2bus_drv_pkg::*;

  logic                  phi0_i;
  logic                  phi0_posedge_i;
  logic                  phi0_negedge_i;
  logic [15:0]           addr_i;
  logic                  rw_n_i;
  logic                  dma_n_i;
  logic                  enable_i;
  logic                  rd_req_o;
  space_t                rd_space_o;
  logic [OFFSET_W-1:0]   rd_offset_o;
  logic [7:0]            rd_data_i;
  logic                  rd_valid_i;
  logic [7:0]            data_o;
  logic                  data_dir_o;
  logic                  data_oe_n_o;
  logic                  miss_o;
  logic                  c8_owner_o;

  modport master (
    input  phi0_i, phi0_posedge_i, phi0_negedge_i, addr_i, rw_n_i, dma_n_i, enable_i,
    input  rd_data_i, rd_valid_i,
    output rd_req_o, rd_space_o, rd_offset_o,
    output data_o, data_dir_o, data_oe_n_o, miss_o, c8_owner_o
  );

  modport slave (
    output phi0_i, phi0_posedge_i, phi0_negedge_i, addr_i, rw_n_i, dma_n_i, enable_i,
    output rd_data_i, rd_valid_i,
    input  rd_req_o, rd_space_o, rd_offset_o,
    input  data_o, data_dir_o, data_oe_n_o, miss_o, c8_owner_o
  );

endinterface

// File: rtl/a2bus_slot_decode.sv
// Slot address decode: DEVSEL/IOSEL/IOSTROBE compare, offset extraction, $C800 owner flag.
module a2bus_slot_decode
  import a2bus_drv_pkg::*;
#(
  parameter int unsigned SLOT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        phi0_posedge,
  input  logic [15:0] addr,
  input  logic        rw_n,
  input  logic        dma_n,
  input  logic        enable,
  output logic        hit_c,
  output rd_sel_t     sel_c,
  output logic        c8_owner
);

  localparam logic [15:0] DEVSEL_ADDR = devsel_addr(SLOT);
  localparam logic [15:0] IOSEL_ADDR  = iosel_addr(SLOT);

  logic devsel_c;
  logic iosel_c;
  logic iostrobe_c;
  logic c8_clear_c;

  // Address compare and read-hit qualification; owner is the pre-update value.
  always_comb begin
    devsel_c   = (addr[15:4] == DEVSEL_ADDR[15:4]);
    iosel_c    = (addr[15:8] == IOSEL_ADDR[15:8]);
    c8_clear_c = (addr == C8_CLEAR_ADDR);
    iostrobe_c = (addr[15:11] == IOSTROBE_BASE[15:11]) && !c8_clear_c;
    hit_c      = enable & dma_n & rw_n & (devsel_c | iosel_c | (iostrobe_c & c8_owner));
    sel_c      = '0;
    if (devsel_c) begin
      sel_c.space  = SPACE_DEVSEL;
      sel_c.offset = OFFSET_W'(addr[3:0]);
    end else if (iosel_c) begin
      sel_c.space  = SPACE_IOSEL;
      sel_c.offset = OFFSET_W'(addr[7:0]);
    end else begin
      sel_c.space  = SPACE_IOSTROBE;
      sel_c.offset = addr[10:0];
    end
  end

  // Expansion-ROM ownership: any IOSEL access claims it, any $CFFF access releases it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      c8_owner <= 1'b0;
    end else if (phi0_posedge) begin
      if (c8_clear_c) begin
        c8_owner <= 1'b0;
      end else if (iosel_c) begin
        c8_owner <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/apple_bus_data_driver.sv
// Slot-card read responder: decodes reads, fetches a byte, drives it onto the bus during Phi0.
module apple_bus_data_driver
  import a2bus_drv_pkg::*;
#(
  parameter int unsigned SLOT           = 4,
  parameter int unsigned DEADLINE_COUNT = 12,
  parameter int unsigned DRIVE_START    = 8,
  parameter int unsigned HOLD_COUNT     = 2
) (
  input  logic                        clk_logic_i,
  input  logic                        system_reset_n_i,
  apple_bus_data_driver_if.master     bus
);

  localparam int unsigned HOLD_W = (HOLD_COUNT < 2) ? 1 : $clog2(HOLD_COUNT + 1);
  localparam logic [CNT_W-1:0]  DEADLINE_C = CNT_W'(DEADLINE_COUNT);
  // Output enable is registered, so arm one count early to be low at DRIVE_START.
  localparam logic [CNT_W-1:0]  OE_ARM_C   = CNT_W'(DRIVE_START - 1);
  localparam logic [HOLD_W-1:0] HOLD_C     = HOLD_W'(HOLD_COUNT);

  state_t              state;
  logic [CNT_W-1:0]    phase_cnt;
  logic [HOLD_W-1:0]   hold_cnt;
  logic                rd_req;
  space_t              rd_space;
  logic [OFFSET_W-1:0] rd_offset;
  logic [7:0]          data;
  logic                data_dir;
  logic                data_oe_n;
  logic                miss;
  logic                hit_c;
  rd_sel_t             sel_c;
  logic                c8_owner;

  a2bus_slot_decode #(
    .SLOT (SLOT)
  ) u_decode (
    .clk          (clk_logic_i),
    .rst_n        (system_reset_n_i),
    .phi0_posedge (bus.phi0_posedge_i),
    .addr         (bus.addr_i),
    .rw_n         (bus.rw_n_i),
    .dma_n        (bus.dma_n_i),
    .enable       (bus.enable_i),
    .hit_c        (hit_c),
    .sel_c        (sel_c),
    .c8_owner     (c8_owner)
  );

  // Phase counter: cycles elapsed since Phi0 rose, saturating.
  always_ff @(posedge clk_logic_i) begin
    if (!system_reset_n_i) begin
      phase_cnt <= '0;
    end else if (bus.phi0_posedge_i) begin
      phase_cnt <= '0;
    end else if (bus.phi0_i && (phase_cnt != CNT_MAX)) begin
      phase_cnt <= phase_cnt + 1'b1;
    end
  end

  // Responder FSM with registered request, data and transceiver controls.
  always_ff @(posedge clk_logic_i) begin
    if (!system_reset_n_i) begin
      state     <= IDLE;
      hold_cnt  <= '0;
      rd_req    <= 1'b0;
      rd_space  <= SPACE_DEVSEL;
      rd_offset <= '0;
      data      <= 8'h00;
      data_dir  <= 1'b0;
      data_oe_n <= 1'b1;
      miss      <= 1'b0;
    end else begin
      rd_req <= 1'b0;
      miss   <= 1'b0;
      if (bus.phi0_posedge_i) begin
        // A new bus cycle always releases the bus and is decoded afresh.
        data_oe_n <= 1'b1;
        data_dir  <= 1'b0;
        if (hit_c) begin
          state     <= REQ;
          rd_req    <= 1'b1;
          rd_space  <= sel_c.space;
          rd_offset <= sel_c.offset;
        end else begin
          state <= IDLE;
        end
      end else begin
        unique case (state)
          IDLE: state <= IDLE;
          REQ: begin
            if (bus.rd_valid_i && (phase_cnt <= DEADLINE_C)) begin
              data     <= bus.rd_data_i;
              data_dir <= 1'b1;
              state    <= DRIVE;
            end else if (phase_cnt >= DEADLINE_C) begin
              miss  <= 1'b1;
              state <= IDLE;
            end
          end
          DRIVE: begin
            if (bus.phi0_negedge_i) begin
              state    <= HOLD;
              hold_cnt <= HOLD_C;
              if (HOLD_COUNT == 0) begin
                data_oe_n <= 1'b1;
              end
            end else if (data_dir && (phase_cnt >= OE_ARM_C)) begin
              data_oe_n <= 1'b0;
            end
          end
          HOLD: begin
            if (hold_cnt != '0) begin
              hold_cnt <= hold_cnt - 1'b1;
              if (hold_cnt == HOLD_W'(1)) begin
                data_oe_n <= 1'b1;
              end
            end else begin
              // Direction turns around only after the enable has been off a cycle.
              data_oe_n <= 1'b1;
              data_dir  <= 1'b0;
              state     <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.rd_req_o    = rd_req;
  assign bus.rd_space_o  = rd_space;
  assign bus.rd_offset_o = rd_offset;
  assign bus.data_o      = data;
  assign bus.data_dir_o  = data_dir;
  assign bus.data_oe_n_o = data_oe_n;
  assign bus.miss_o      = miss;
  assign bus.c8_owner_o  = c8_owner;

endmodule
